// File: rtl/riscv32_muldiv_seq.sv
// riscv32_muldiv_seq
// Multi-cycle RV32M sequencer: iterative shift-add multiply and restoring
// divide, one bit per cycle, over one shared 33-bit add/subtract datapath.
// Special divides (divide by zero, signed overflow) skip the iteration phase.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (wins over start and flush)
//   start     request, accepted only while ready=1
//   flush     aborts an in-flight op; blocks a same-cycle start
//   op        RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op1_data  rs1 value (multiplicand / dividend)
//   op2_data  rs2 value (multiplier / divisor)
//   ready     high in IDLE and DONE
//   busy      high in CALC and FIX
//   done      one-cycle pulse, result valid
//   result    final value, updated only when FIX completes
module riscv32_muldiv_seq #(
    parameter int XLEN   = 32,
    parameter int OP_LEN = 3,
    parameter int ITER   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [OP_LEN-1:0] op,
    input  logic [XLEN-1:0]   op1_data,
    input  logic [XLEN-1:0]   op2_data,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result
);

    localparam int CW = $clog2(ITER);

    localparam logic [OP_LEN-1:0] OP_MUL    = 3'b000;
    localparam logic [OP_LEN-1:0] OP_MULH   = 3'b001;
    localparam logic [OP_LEN-1:0] OP_MULHSU = 3'b010;
    localparam logic [OP_LEN-1:0] OP_DIV    = 3'b100;
    localparam logic [OP_LEN-1:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [OP_LEN-1:0] op_q;
    logic [XLEN-1:0]   hi;       // product high / partial remainder / special result
    logic [XLEN-1:0]   lo;       // multiplier bits / quotient bits
    logic [XLEN-1:0]   opb;      // multiplicand or divisor magnitude
    logic              neg1;
    logic              neg2;
    logic              special;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return (~v) + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
        return (~v) + (2*XLEN)'(1);
    endfunction

    // Operand conditioning for the incoming request
    logic            s1, s2, a_neg, b_neg, div_zero, ovf, is_special, accept;
    logic [XLEN-1:0] a_mag, b_mag, spec_val;

    always_comb begin
        s1       = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        s2       = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = s1 && op1_data[XLEN-1];
        b_neg    = s2 && op2_data[XLEN-1];
        a_mag    = a_neg ? neg_w(op1_data) : op1_data;
        b_mag    = b_neg ? neg_w(op2_data) : op2_data;
        div_zero = op[2] && (op2_data == '0);
        ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                   (op1_data == {1'b1, {(XLEN-1){1'b0}}}) && (op2_data == '1);
        is_special = div_zero || ovf;
        // op[1] separates remainder ops from quotient ops within the divide group
        if (div_zero)
            spec_val = op[1] ? op1_data : '1;
        else
            spec_val = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        accept = start && !flush && ((state == S_IDLE) || (state == S_DONE));
    end

    // Shared 33-bit adder: add for multiply, subtract (a + ~b + 1) for divide
    logic          is_div;
    logic [XLEN:0] shifted, add_a, add_b, sum;

    always_comb begin
        is_div  = op_q[2];
        shifted = {hi, lo[XLEN-1]};
        add_a   = is_div ? shifted : {1'b0, hi};
        if (is_div)
            add_b = ~{1'b0, opb};
        else
            add_b = lo[0] ? {1'b0, opb} : '0;
        sum = add_a + add_b + {{XLEN{1'b0}}, is_div};
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = {hi, lo};
        if (neg1 ^ neg2)
            prod = neg_dw(prod);
        quo = (neg1 ^ neg2) ? neg_w(lo) : lo;
        rem = neg1 ? neg_w(hi) : hi;
        case (op_q)
            OP_MUL:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
        if (special)
            fix_res = hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q    <= op;
                        neg1    <= a_neg;
                        neg2    <= b_neg;
                        special <= is_special;
                        opb     <= is_special ? '0 : b_mag;
                        cnt     <= '0;
                        if (is_special) begin
                            hi    <= spec_val;
                            lo    <= '0;
                            state <= S_FIX;
                        end else begin
                            // multiply: lo holds the multiplier, opb the multiplicand
                            // divide:   lo holds the dividend,   opb the divisor
                            hi    <= '0;
                            lo    <= op[2] ? a_mag : b_mag;
                            opb   <= op[2] ? b_mag : a_mag;
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            // sum[XLEN] is the sign of the trial subtraction
                            if (!sum[XLEN]) begin
                                hi <= sum[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                hi <= shifted[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            hi <= sum[XLEN:1];
                            lo <= {sum[0], lo[XLEN-1:1]};
                        end
                        if (cnt == CW'(ITER - 1))
                            state <= S_FIX;
                        else
                            cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= fix_res;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_IDLE) || (state == S_DONE);
    assign busy  = (state == S_CALC) || (state == S_FIX);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_riscv32_muldiv_seq.sv
`timescale 1ns/1ps
module tb_riscv32_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] op1_data;
    logic [31:0] op2_data;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    riscv32_muldiv_seq #(.XLEN(32), .OP_LEN(3), .ITER(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .op1_data (op1_data),
        .op2_data (op2_data),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for done; lat is the done cycle
    // counted from the start cycle (cycle 0).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        op = o; op1_data = a; op2_data = b; start = 1'b1;
        tick;
        start = 1'b0;
        op1_data = ~a;
        op2_data = b + 32'd1;
        lat = 1;
        while (!done && lat < 100) begin
            tick;
            lat++;
        end
        res = result;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b done=%b result=%h, need 1 0 0 00000000",
                     ready, busy, done, result);
        end
    endtask

    task automatic test_mul_latency;
        int cyc;
        int ready_hi;
        int busy_lo;
        op = 3'b000; op1_data = 32'd7; op2_data = 32'hFFFFFFFD; start = 1'b1;
        tick;
        start = 1'b0;
        op1_data = 32'h12345678;
        op2_data = 32'h0;
        cyc = 1; ready_hi = 0; busy_lo = 0;
        while (!done && cyc < 100) begin
            if (ready) ready_hi++;
            if (!busy) busy_lo++;
            tick;
            cyc++;
        end
        checks++;
        if (cyc !== 34) begin
            errors++;
            $display("FAIL mul_latency: done in cycle %0d, need 34", cyc);
        end
        checks++;
        if (result !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mul_result: got %h, need FFFFFFEB", result);
        end
        checks++;
        if (ready_hi !== 0 || busy_lo !== 0) begin
            errors++;
            $display("FAIL mul_ready_busy: ready high %0d / busy low %0d cycles in 1..33, need 0",
                     ready_hi, busy_lo);
        end
        tick;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_after: done=%b ready=%b, need 0 1", done, ready);
        end
    endtask

    task automatic test_mul_high;
        logic [2:0]  ops [3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res);
            checks++;
            if (res !== exp[i] || lat !== 34) begin
                errors++;
                $display("FAIL mul_high[%0d] op=%b: result %h cycle %0d, need %h cycle 34",
                         i, ops[i], res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_divide;
        logic [2:0]  ops [5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100};
        logic [31:0] as  [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd100};
        logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9};
        logic [31:0] exp [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFF2};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res);
            checks++;
            if (res !== exp[i] || lat !== 34) begin
                errors++;
                $display("FAIL divide[%0d] op=%b: result %h cycle %0d, need %h cycle 34",
                         i, ops[i], res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_fast_path;
        logic [2:0]  ops [6] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b111, 3'b100};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res);
            checks++;
            if (res !== exp[i] || lat !== 2) begin
                errors++;
                $display("FAIL fast_path[%0d] op=%b: result %h cycle %0d, need %h cycle 2",
                         i, ops[i], res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int nd;
        int d1;
        int d2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] r35;
        nd = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0; r35 = '0;
        op = 3'b000; op1_data = 32'd3; op2_data = 32'd4; start = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            tick;
            start = 1'b0;
            if (i == 35) r35 = result;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    d1 = i; r1 = result;
                    op = 3'b101; op1_data = 32'd9; op2_data = 32'd3; start = 1'b1;
                end else begin
                    d2 = i; r2 = result;
                end
            end
            if (i == 10) begin
                op = 3'b100; op1_data = 32'd100; op2_data = 32'd7; start = 1'b1;
            end
        end
        checks++;
        if (d1 !== 34 || r1 !== 32'd12) begin
            errors++;
            $display("FAIL b2b_first: done cycle %0d result %h, need 34 0000000c", d1, r1);
        end
        checks++;
        if (d2 !== 68 || r2 !== 32'd3) begin
            errors++;
            $display("FAIL b2b_second: done cycle %0d result %h, need 68 00000003", d2, r2);
        end
        checks++;
        if (nd !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: %0d done pulses, need 2", nd);
        end
        checks++;
        if (r35 !== 32'd12) begin
            errors++;
            $display("FAIL b2b_hold: result in cycle 35 %h, need 0000000c", r35);
        end
    endtask

    task automatic test_flush;
        int nd;
        int busy10;
        logic [31:0] res11;
        logic rdy11;
        logic bsy11;
        nd = 0; busy10 = 0; res11 = '0; rdy11 = 1'b0; bsy11 = 1'b1;
        op = 3'b100; op1_data = 32'd100; op2_data = 32'd7; start = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick;
            start = 1'b0;
            flush = 1'b0;
            if (done) nd++;
            if (i == 10) begin
                busy10 = busy;
                flush = 1'b1;
            end
            if (i == 11) begin
                rdy11 = ready; bsy11 = busy; res11 = result;
            end
        end
        checks++;
        if (busy10 !== 1 || rdy11 !== 1'b1 || bsy11 !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: busy@10=%0d ready@11=%b busy@11=%b, need 1 1 0",
                     busy10, rdy11, bsy11);
        end
        checks++;
        if (res11 !== 32'd3 || nd !== 0) begin
            errors++;
            $display("FAIL flush_result: result %h done pulses %0d, need 00000003 0", res11, nd);
        end
        // start together with flush while idle must be ignored
        op = 3'b101; op1_data = 32'd9; op2_data = 32'd0; start = 1'b1; flush = 1'b1;
        tick;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_start: busy=%b ready=%b, need 0 1", busy, ready);
        end
        tick;
        checks++;
        if (done !== 1'b0 || result !== 32'd3) begin
            errors++;
            $display("FAIL flush_idle_done: done=%b result %h, need 0 00000003", done, result);
        end
    endtask

    task automatic test_reset_midop;
        int lat;
        logic [31:0] res;
        op = 3'b000; op1_data = 32'd5; op2_data = 32'd6; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            start = 1'b0;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop: ready=%b busy=%b done=%b result=%h, need 1 0 0 00000000",
                     ready, busy, done, result);
        end
        run_op(3'b000, 32'd5, 32'd6, lat, res);
        checks++;
        if (res !== 32'd30 || lat !== 34) begin
            errors++;
            $display("FAIL reset_recover: result %h cycle %0d, need 0000001e cycle 34", res, lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 3'b000;
        op1_data = '0;
        op2_data = '0;
        test_reset;
        test_mul_latency;
        test_mul_high;
        test_divide;
        test_fast_path;
        test_back_to_back;
        test_flush;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
